// File: rtl/uart_xmit_cfg.sv
// ============================================================================
// Module   : uart_xmit_cfg
// Brief    : Parametrised UART transmitter (start, DATA_BITS LSB-first,
//            optional parity, 1/2 stop bits). Define XMIT_HOLD_EN to add a
//            one-entry holding register for back-to-back frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_xmit_cfg #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 xmitH,
    input  logic [DATA_BITS-1:0] xmit_dataH,
    output logic                 xmit_readyH,
    output logic                 uart_xmitH,
    output logic                 xmit_doneH
);

    localparam int            CW        = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] CELL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_xmit_cfg: DATA_BITS must be 5..9");
    end
    if (OVERSAMPLE < 4 || OVERSAMPLE > 256) begin : g_bad_oversample
        $error("uart_xmit_cfg: OVERSAMPLE must be 4..256");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_xmit_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_xmit_cfg: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cell_q, cell_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic                   line_q, line_d;
    logic                   done_q, done_d;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_cell_end;
    logic                   w_frame_end;
    logic                   w_load;
    logic [DATA_BITS-1:0]   w_load_data;

    assign w_accept    = xmitH & w_ready;
    assign w_cell_end  = (cell_q == CELL_LAST);
    assign w_frame_end = (state_q == S_STOP) && w_cell_end && (bit_q == STOP_LAST);

`ifdef XMIT_HOLD_EN
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic                   hold_valid_q, hold_valid_d;

    assign w_ready     = ~hold_valid_q;
    // A pending word wins at frame end; otherwise a same-cycle request starts directly.
    assign w_load      = ((state_q == S_IDLE) && w_accept) ||
                         (w_frame_end && (hold_valid_q || w_accept));
    assign w_load_data = hold_valid_q ? hold_q : xmit_dataH;
`else
    assign w_ready     = (state_q == S_IDLE);
    assign w_load      = w_accept;
    assign w_load_data = xmit_dataH;
`endif

    always_comb begin
        state_d  = state_q;
        cell_d   = (state_q == S_IDLE || w_cell_end) ? '0 : cell_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        done_d   = 1'b0;

        // Line follows the state one clock later so the pin is a clean flop.
        case (state_q)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shift_q[0];
            S_PARITY: line_d = parity_q;
            default:  line_d = 1'b1;
        endcase

        case (state_q)
            S_START: begin
                if (w_cell_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (w_cell_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_cell_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (w_cell_end) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (w_load) begin
            state_d  = S_START;
            cell_d   = '0;
            bit_d    = '0;
            shift_d  = w_load_data;
            parity_d = (PARITY_MODE == 2) ? ~^w_load_data : ^w_load_data;
        end
    end

`ifdef XMIT_HOLD_EN
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (w_frame_end && hold_valid_q) begin
            hold_valid_d = 1'b0;
        end else if (w_accept && state_q != S_IDLE && !w_frame_end) begin
            hold_d       = xmit_dataH;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            cell_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            line_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cell_q   <= cell_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            line_q   <= line_d;
            done_q   <= done_d;
        end
    end

    assign xmit_readyH = w_ready;
    assign uart_xmitH  = line_q;
    assign xmit_doneH  = done_q;

endmodule

`default_nettype wire
